// File: rtl/execute_mdu.sv
// execute_mdu: execute-stage RV32M multiply/divide unit.
// Accepts an M-extension op from the decode->execute register, runs it
// (iterative shift-add multiply, restoring radix-2 divide) and hands the
// result to the execute->memory register through a valid/allow-in pair.
// Optional build macro: MDU_FAST_MUL_EN -- multiplies use a single-cycle
// combinational product and finish one edge after accept; divides unchanged.
//
// Handshake: upstream advances on decode_vaild_i & execute_allow_in_o at a
// rising edge; downstream takes the result on execute_ready_o &
// memory_allow_in_i at a rising edge; the result and destination stay stable
// while execute_ready_o=1 and memory_allow_in_i=0.
// FSM state is visible through mdu_busy_o (IDLE vs not) and execute_ready_o
// (DONE vs CALC).
module execute_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            decode_vaild_i,
  input  logic            DD_mdu_en_i,
  input  logic [2:0]      DD_mdu_op_i,
  input  logic [XLEN-1:0] DD_rs1_data_i,
  input  logic [XLEN-1:0] DD_rs2_data_i,
  input  logic [4:0]      DD_dstE_i,
  input  logic            flush_i,
  input  logic            memory_allow_in_i,
  output logic            execute_allow_in_o,
  output logic            execute_ready_o,
  output logic [XLEN-1:0] E_mdu_result_o,
  output logic [4:0]      E_dstE_o,
  output logic            mdu_busy_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a;       // multiplicand / divisor-independent magnitude of rs1
  logic [XLEN-1:0]     r_b;       // divisor magnitude
  logic [XLEN-1:0]     r_rem;     // partial remainder
  logic [XLEN-1:0]     r_quo;     // dividend shifting out, quotient shifting in
  logic [2*XLEN-1:0]   r_acc;     // {product high, multiplier/product low}
  logic                r_neg;     // negate final result
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_dst;
  logic                r_ready;
  logic                r_busy;

  logic                w_accept;
  logic                w_allow;
  logic                w_is_div;
  logic                w_a_sgn;
  logic                w_b_sgn;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_start_neg;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;
  logic                w_fast;
  logic [XLEN-1:0]     w_fast_res;

  logic [XLEN:0]       w_trial;
  logic                w_qbit;
  logic [XLEN-1:0]     w_rem_next;
  logic [XLEN-1:0]     w_quo_next;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_prod_final;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN-1:0]     w_div_sel;
  logic [XLEN-1:0]     w_div_res;
  logic [XLEN-1:0]     w_calc_res;

  // Upstream allow-in purely from state: free in IDLE, follows downstream in DONE.
  always_comb begin
    w_allow = 1'b0;
    case (r_state)
      S_IDLE:  w_allow = 1'b1;
      S_DONE:  w_allow = memory_allow_in_i;
      default: w_allow = 1'b0;
    endcase
  end

  assign w_accept = decode_vaild_i & DD_mdu_en_i & w_allow;

  // Decode the incoming op: operand magnitudes, result sign and special cases.
  always_comb begin
    w_is_div    = DD_mdu_op_i[2];
    w_a_sgn     = (DD_mdu_op_i == 3'd1) | (DD_mdu_op_i == 3'd2) |
                  (DD_mdu_op_i == 3'd4) | (DD_mdu_op_i == 3'd6);
    w_b_sgn     = (DD_mdu_op_i == 3'd1) | (DD_mdu_op_i == 3'd4) |
                  (DD_mdu_op_i == 3'd6);
    w_a_neg     = w_a_sgn & DD_rs1_data_i[XLEN-1];
    w_b_neg     = w_b_sgn & DD_rs2_data_i[XLEN-1];
    w_a_mag     = w_a_neg ? -DD_rs1_data_i : DD_rs1_data_i;
    w_b_mag     = w_b_neg ? -DD_rs2_data_i : DD_rs2_data_i;
    // Remainder takes the dividend sign; quotient and product take the XOR.
    w_start_neg = (w_is_div & DD_mdu_op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero  = w_is_div & (DD_rs2_data_i == '0);
    w_div_ovf   = w_is_div & ~DD_mdu_op_i[0] & (DD_rs1_data_i == INT_MIN) &
                  (DD_rs2_data_i == '1);
    w_special   = w_div_zero | w_div_ovf;
    if (w_div_zero) begin
      w_special_res = DD_mdu_op_i[1] ? DD_rs1_data_i : '1;
    end else begin
      w_special_res = DD_mdu_op_i[1] ? '0 : INT_MIN;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_mag;
  logic [2*XLEN-1:0] w_fast_prod;

  // Single-cycle product on magnitudes, sign restored afterwards.
  always_comb begin
    w_fast_mag  = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
    w_fast_prod = w_start_neg ? -w_fast_mag : w_fast_mag;
    w_fast_res  = (DD_mdu_op_i == 3'd0) ? w_fast_prod[XLEN-1:0]
                                        : w_fast_prod[2*XLEN-1:XLEN];
    w_fast      = ~w_is_div;
  end
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  // One iteration of restoring divide and shift-add multiply, plus final fixup.
  always_comb begin
    w_trial      = {r_rem, r_quo[XLEN-1]} - {1'b0, r_b};
    w_qbit       = ~w_trial[XLEN];
    w_rem_next   = w_qbit ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    w_quo_next   = {r_quo[XLEN-2:0], w_qbit};
    w_sum        = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_acc_next   = {w_sum, r_acc[XLEN-1:1]};
    w_prod_final = r_neg ? -w_acc_next : w_acc_next;
    w_mul_res    = (r_op == 3'd0) ? w_prod_final[XLEN-1:0]
                                  : w_prod_final[2*XLEN-1:XLEN];
    w_div_sel    = r_op[1] ? w_rem_next : w_quo_next;
    w_div_res    = r_neg ? -w_div_sel : w_div_sel;
    w_calc_res   = r_op[2] ? w_div_res : w_mul_res;
  end

  // Control FSM and datapath registers; flush kills the op and wins over accept.
  always_ff @(posedge clk_i) begin
    if (rst | flush_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_dst    <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_accept) begin
      // Only reachable from IDLE, or from DONE while downstream takes the result.
      r_op  <= DD_mdu_op_i;
      r_dst <= DD_dstE_i;
      r_a   <= w_a_mag;
      r_b   <= w_b_mag;
      r_quo <= w_a_mag;
      r_rem <= '0;
      r_acc <= {{XLEN{1'b0}}, w_b_mag};
      r_neg <= w_start_neg;
      r_busy <= 1'b1;
      if (w_special) begin
        r_state  <= S_DONE;
        r_result <= w_special_res;
        r_ready  <= 1'b1;
        r_cnt    <= '0;
      end else if (w_fast) begin
        r_state  <= S_DONE;
        r_result <= w_fast_res;
        r_ready  <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_state  <= S_CALC;
        r_ready  <= 1'b0;
        r_cnt    <= CNT_INIT;
      end
    end else begin
      case (r_state)
        S_CALC: begin
          r_acc <= w_acc_next;
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state  <= S_DONE;
            r_result <= w_calc_res;
            r_ready  <= 1'b1;
          end
        end
        S_DONE: begin
          if (memory_allow_in_i) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign execute_allow_in_o = w_allow;
  assign execute_ready_o    = r_ready;
  assign E_mdu_result_o     = r_result;
  assign E_dstE_o           = r_dst;
  assign mdu_busy_o         = r_busy;

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: directed bench for execute_mdu (latency, results, special
// cases, backpressure, back-to-back, flush and reset).
module tb_execute_mdu;

  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  // clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst;
  logic            decode_vaild_i;
  logic            DD_mdu_en_i;
  logic [2:0]      DD_mdu_op_i;
  logic [XLEN-1:0] DD_rs1_data_i;
  logic [XLEN-1:0] DD_rs2_data_i;
  logic [4:0]      DD_dstE_i;
  logic            flush_i;
  logic            memory_allow_in_i;
  logic            execute_allow_in_o;
  logic            execute_ready_o;
  logic [XLEN-1:0] E_mdu_result_o;
  logic [4:0]      E_dstE_o;
  logic            mdu_busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  execute_mdu #(.XLEN(XLEN)) dut (
    .clk_i              (clk_i),
    .rst                (rst),
    .decode_vaild_i     (decode_vaild_i),
    .DD_mdu_en_i        (DD_mdu_en_i),
    .DD_mdu_op_i        (DD_mdu_op_i),
    .DD_rs1_data_i      (DD_rs1_data_i),
    .DD_rs2_data_i      (DD_rs2_data_i),
    .DD_dstE_i          (DD_dstE_i),
    .flush_i            (flush_i),
    .memory_allow_in_i  (memory_allow_in_i),
    .execute_allow_in_o (execute_allow_in_o),
    .execute_ready_o    (execute_ready_o),
    .E_mdu_result_o     (E_mdu_result_o),
    .E_dstE_o           (E_dstE_o),
    .mdu_busy_o         (mdu_busy_o)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dst);
    decode_vaild_i = 1'b1;
    DD_mdu_en_i    = 1'b1;
    DD_mdu_op_i    = op;
    DD_rs1_data_i  = a;
    DD_rs2_data_i  = b;
    DD_dstE_i      = dst;
  endtask

  task automatic idle_inputs();
    decode_vaild_i = 1'b0;
    DD_mdu_en_i    = 1'b0;
  endtask

  // Present an op for one edge, then count edges until ready (bounded).
  task automatic issue_and_wait(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] dst,
                                output int lat);
    drive_op(op, a, b, dst);
    tick();
    idle_inputs();
    lat = 0;
    while (!execute_ready_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", execute_ready_o); end
    n_vec++; if (E_mdu_result_o !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", E_mdu_result_o); end
    n_vec++; if (E_dstE_o !== 5'd0) begin n_err++; $display("FAIL reset_dst: got %0d expected 0", E_dstE_o); end
    n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", mdu_busy_o); end
    n_vec++; if (execute_allow_in_o !== 1'b1) begin n_err++; $display("FAIL reset_allow: got %b expected 1", execute_allow_in_o); end
    // reset in the middle of an iterative divide
    drive_op(3'd5, 32'd100, 32'd7, 5'd4);
    tick();
    idle_inputs();
    repeat (9) tick();
    n_vec++; if (mdu_busy_o !== 1'b1) begin n_err++; $display("FAIL midcalc_busy: got %b expected 1", mdu_busy_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", mdu_busy_o); end
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL midreset_ready: got %b expected 0", execute_ready_o); end
    n_vec++; if (execute_allow_in_o !== 1'b1) begin n_err++; $display("FAIL midreset_allow: got %b expected 1", execute_allow_in_o); end
    lat = 0;
    repeat (30) tick();
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL midreset_noresult: got %b expected 0", execute_ready_o); end
  endtask

  // Iterative path, special cases and multiplies from one directed table.
  task automatic test_arith();
    logic [2:0]  ops  [14];
    logic [31:0] as   [14];
    logic [31:0] bs   [14];
    logic [31:0] exps [14];
    int          lats [14];
    int lat;
    ops  = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6,
             3'd4, 3'd6, 3'd5, 3'd7,
             3'd1, 3'd0, 3'd2, 3'd3};
    as   = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'd100,
             32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5,
             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs   = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd2,
             32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd5,
             32'h4000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    lats = '{DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT,
             0, 0, 0, 0,
             MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT};
    memory_allow_in_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      issue_and_wait(ops[i], as[i], bs[i], 5'(i + 1), lat);
      n_vec++; if (execute_ready_o !== 1'b1) begin n_err++; $display("FAIL arith%0d_ready: got %b expected 1 (op %0d)", i, execute_ready_o, ops[i]); end
      n_vec++; if (E_mdu_result_o !== exps[i]) begin n_err++; $display("FAIL arith%0d_result: got %h expected %h (op %0d a %h b %h)", i, E_mdu_result_o, exps[i], ops[i], as[i], bs[i]); end
      n_vec++; if (E_dstE_o !== 5'(i + 1)) begin n_err++; $display("FAIL arith%0d_dst: got %0d expected %0d", i, E_dstE_o, i + 1); end
      n_vec++; if (lat !== lats[i]) begin n_err++; $display("FAIL arith%0d_latency: got %0d expected %0d", i, lat, lats[i]); end
      tick();
      n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL arith%0d_release: busy %b expected 0", i, mdu_busy_o); end
    end
  endtask

  task automatic test_non_mdu();
    decode_vaild_i = 1'b1;
    DD_mdu_en_i    = 1'b0;
    DD_mdu_op_i    = 3'd5;
    DD_rs1_data_i  = 32'd5;
    DD_rs2_data_i  = 32'd0;
    tick();
    idle_inputs();
    n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL nonmdu_busy: got %b expected 0", mdu_busy_o); end
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL nonmdu_ready: got %b expected 0", execute_ready_o); end
  endtask

  task automatic test_backpressure();
    int lat;
    memory_allow_in_i = 1'b0;
    issue_and_wait(3'd5, 32'd100, 32'd7, 5'd9, lat);
    n_vec++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL bp_latency: got %0d expected %0d", lat, DIV_LAT); end
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (execute_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d_ready: got %b expected 1", k, execute_ready_o); end
      n_vec++; if (E_mdu_result_o !== 32'd14) begin n_err++; $display("FAIL bp_hold%0d_result: got %h expected 0000000e", k, E_mdu_result_o); end
      n_vec++; if (E_dstE_o !== 5'd9) begin n_err++; $display("FAIL bp_hold%0d_dst: got %0d expected 9", k, E_dstE_o); end
      n_vec++; if (execute_allow_in_o !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d_allow: got %b expected 0", k, execute_allow_in_o); end
      tick();
    end
    // release together with a new accept: no bubble
    memory_allow_in_i = 1'b1;
    drive_op(3'd7, 32'd100, 32'd7, 5'd10);
    #1;
    n_vec++; if (execute_allow_in_o !== 1'b1) begin n_err++; $display("FAIL bp_release_allow: got %b expected 1", execute_allow_in_o); end
    tick();
    idle_inputs();
    n_vec++; if (mdu_busy_o !== 1'b1) begin n_err++; $display("FAIL bp_next_busy: got %b expected 1", mdu_busy_o); end
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_next_ready: got %b expected 0", execute_ready_o); end
    lat = 0;
    while (!execute_ready_o && lat < 40) begin
      tick();
      lat++;
    end
    n_vec++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL bp_next_latency: got %0d expected %0d", lat, DIV_LAT); end
    n_vec++; if (E_mdu_result_o !== 32'd2) begin n_err++; $display("FAIL bp_next_result: got %h expected 00000002", E_mdu_result_o); end
    n_vec++; if (E_dstE_o !== 5'd10) begin n_err++; $display("FAIL bp_next_dst: got %0d expected 10", E_dstE_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp;
    memory_allow_in_i = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'h8000_0000);
    drive_op(3'd5, 32'd5, 32'd0, 5'd11);
    tick();
    drive_op(3'd7, 32'd5, 32'd0, 5'd12);
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      n_vec++; if (execute_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b%0d_ready: got %b expected 1", k, execute_ready_o); end
      n_vec++; if (E_mdu_result_o !== exp) begin n_err++; $display("FAIL b2b%0d_result: got %h expected %h", k, E_mdu_result_o, exp); end
      n_vec++; if (E_dstE_o !== 5'(11 + k)) begin n_err++; $display("FAIL b2b%0d_dst: got %0d expected %0d", k, E_dstE_o, 11 + k); end
      if (k == 0) drive_op(3'd7, 32'd5, 32'd0, 5'd12);
      if (k == 1) drive_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
      if (k == 2) idle_inputs();
      tick();
    end
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_end_ready: got %b expected 0", execute_ready_o); end
  endtask

  task automatic test_flush();
    int lat;
    memory_allow_in_i = 1'b1;
    // flush in the accept cycle: nothing captured
    drive_op(3'd4, 32'd100, 32'd7, 5'd20);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    idle_inputs();
    n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL flush_accept_busy: got %b expected 0", mdu_busy_o); end
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_accept_ready: got %b expected 0", execute_ready_o); end
    n_vec++; if (E_dstE_o !== 5'd0) begin n_err++; $display("FAIL flush_accept_dst: got %0d expected 0", E_dstE_o); end
    // flush while DONE is held by backpressure
    memory_allow_in_i = 1'b0;
    issue_and_wait(3'd5, 32'd5, 32'd0, 5'd3, lat);
    n_vec++; if (execute_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_done_pre_ready: got %b expected 1", execute_ready_o); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    memory_allow_in_i = 1'b1;
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_done_ready: got %b expected 0", execute_ready_o); end
    n_vec++; if (E_mdu_result_o !== 32'h0) begin n_err++; $display("FAIL flush_done_result: got %h expected 00000000", E_mdu_result_o); end
    n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL flush_done_busy: got %b expected 0", mdu_busy_o); end
    // flush during CALC: the result never appears
    drive_op(3'd5, 32'd100, 32'd7, 5'd6);
    tick();
    idle_inputs();
    repeat (5) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_vec++; if (mdu_busy_o !== 1'b0) begin n_err++; $display("FAIL flush_calc_busy: got %b expected 0", mdu_busy_o); end
    lat = 0;
    while (!execute_ready_o && lat < 40) begin
      tick();
      lat++;
    end
    n_vec++; if (execute_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_calc_ready: got %b expected 0", execute_ready_o); end
  endtask

  initial begin
    rst               = 1'b1;
    decode_vaild_i    = 1'b0;
    DD_mdu_en_i       = 1'b0;
    DD_mdu_op_i       = 3'd0;
    DD_rs1_data_i     = '0;
    DD_rs2_data_i     = '0;
    DD_dstE_i         = '0;
    flush_i           = 1'b0;
    memory_allow_in_i = 1'b1;
    test_reset();
    test_arith();
    test_non_mdu();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
